// File: rtl/mul_pkg.sv
// Shared types and constants for the pipelined RV32M multiplier.
package mul_pkg;

  // Which half of the product is returned and how each operand is extended.
  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,  // MUL: low word, signedness irrelevant
    MUL_HSS = 2'b01,  // MULH: signed x signed, high word
    MUL_HSU = 2'b10,  // MULHSU: signed x unsigned, high word
    MUL_HUU = 2'b11   // MULHU: unsigned x unsigned, high word
  } mul_op_t;

  // Edges from op acceptance to result visibility.
  localparam int unsigned MUL_LATENCY = 2;

  // RV32M funct3 values for the multiply group (opcode OP, funct7 0000001).
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

  // Decoder helper: funct3 of a multiply instruction to multiplier op.
  function automatic mul_op_t funct3_to_op(input logic [2:0] funct3);
    mul_op_t op;
    case (funct3)
      FUNCT3_MUL:    op = MUL_LO;
      FUNCT3_MULH:   op = MUL_HSS;
      FUNCT3_MULHSU: op = MUL_HSU;
      FUNCT3_MULHU:  op = MUL_HUU;
      default:       op = MUL_LO;
    endcase
    return op;
  endfunction

  // Operand a is treated as signed for MULH and MULHSU.
  function automatic logic a_is_signed(input mul_op_t op);
    return (op == MUL_HSS) || (op == MUL_HSU);
  endfunction

  // Operand b is treated as signed for MULH only.
  function automatic logic b_is_signed(input mul_op_t op);
    return (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// Combinational 33x33 operand extension and four-way partial product split.
// Each 33-bit operand is cut into a signed 17-bit high part and an unsigned
// 16-bit low part, so every partial product fits a 17x17 signed multiplier.
module mul_pp_stage
  import mul_pkg::*;
(
  input  mul_op_t      op,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  output logic [31:0]  pp_ll,
  output logic [33:0]  pp_lh,
  output logic [33:0]  pp_hl,
  output logic [33:0]  pp_hh
);

  logic [32:0] a33;
  logic [32:0] b33;

  logic [15:0] al;
  logic [15:0] bl;
  logic [16:0] ah;
  logic [16:0] bh;

  // 34-bit signed views of each half so the products come out at full width
  logic signed [33:0] al_x;
  logic signed [33:0] bl_x;
  logic signed [33:0] ah_x;
  logic signed [33:0] bh_x;

  // Extend operands to 33 bits according to op signedness, then split.
  always_comb begin
    a33  = {a_is_signed(op) & a[31], a};
    b33  = {b_is_signed(op) & b[31], b};
    al   = a33[15:0];
    bl   = b33[15:0];
    ah   = a33[32:16];
    bh   = b33[32:16];
    al_x = $signed({18'b0, al});
    bl_x = $signed({18'b0, bl});
    ah_x = $signed({{17{ah[16]}}, ah});
    bh_x = $signed({{17{bh[16]}}, bh});
  end

  // Partial products; the true values fit in the declared widths.
  always_comb begin
    pp_ll = {16'b0, al} * {16'b0, bl};
    pp_lh = al_x * bh_x;
    pp_hl = ah_x * bl_x;
    pp_hh = ah_x * bh_x;
  end

endmodule

// File: rtl/mul_pipelined.sv
// Two-stage pipelined 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
// Stage 1 registers the partial products; stage 2 sums them and registers the
// selected half. Stall holds everything, flush kills both stages, reset wins.
module mul_pipelined
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag
);

  mul_op_t op_in;

  logic [31:0] pp_ll;
  logic [33:0] pp_lh;
  logic [33:0] pp_hl;
  logic [33:0] pp_hh;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  mul_op_t          s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [31:0]      s1_pp_ll_q, s1_pp_ll_d;
  logic [33:0]      s1_pp_lh_q, s1_pp_lh_d;
  logic [33:0]      s1_pp_hl_q, s1_pp_hl_d;
  logic [33:0]      s1_pp_hh_q, s1_pp_hh_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [31:0]      s2_result_q, s2_result_d;

  logic [63:0] prod;
  logic [31:0] sel;

  assign op_in = mul_op_t'(i_op);

  mul_pp_stage u_pp_stage (
    .op    (op_in),
    .a     (i_a),
    .b     (i_b),
    .pp_ll (pp_ll),
    .pp_lh (pp_lh),
    .pp_hl (pp_hl),
    .pp_hh (pp_hh)
  );

  // Sum the stage-1 partial products modulo 2^64 and pick the requested half.
  always_comb begin
    prod = {32'b0, s1_pp_ll_q}
         + ({{30{s1_pp_lh_q[33]}}, s1_pp_lh_q} << 16)
         + ({{30{s1_pp_hl_q[33]}}, s1_pp_hl_q} << 16)
         + ({{30{s1_pp_hh_q[33]}}, s1_pp_hh_q} << 32);
    sel  = (s1_op_q == MUL_LO) ? prod[31:0] : prod[63:32];
  end

  // Pipeline next state: flush kills valids, stall holds, otherwise advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_tag_d    = s1_tag_q;
    s1_pp_ll_d  = s1_pp_ll_q;
    s1_pp_lh_d  = s1_pp_lh_q;
    s1_pp_hl_d  = s1_pp_hl_q;
    s1_pp_hh_d  = s1_pp_hh_q;
    s2_valid_d  = s2_valid_q;
    s2_tag_d    = s2_tag_q;
    s2_result_d = s2_result_q;

    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (!i_stall) begin
      s1_valid_d  = i_valid;
      s1_op_d     = op_in;
      s1_tag_d    = i_tag;
      s1_pp_ll_d  = pp_ll;
      s1_pp_lh_d  = pp_lh;
      s1_pp_hl_d  = pp_hl;
      s1_pp_hh_d  = pp_hh;
      s2_valid_d  = s1_valid_q;
      s2_tag_d    = s1_tag_q;
      s2_result_d = sel;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= MUL_LO;
      s1_tag_q    <= '0;
      s1_pp_ll_q  <= '0;
      s1_pp_lh_q  <= '0;
      s1_pp_hl_q  <= '0;
      s1_pp_hh_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_result_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_tag_q    <= s1_tag_d;
      s1_pp_ll_q  <= s1_pp_ll_d;
      s1_pp_lh_q  <= s1_pp_lh_d;
      s1_pp_hl_q  <= s1_pp_hl_d;
      s1_pp_hh_q  <= s1_pp_hh_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_result_q <= s2_result_d;
    end
  end

  // Outputs are forced to zero whenever stage 2 holds no valid op.
  always_comb begin
    o_valid  = s2_valid_q;
    o_result = s2_result_q & {32{s2_valid_q}};
    o_tag    = s2_tag_q & {TAG_W{s2_valid_q}};
  end

endmodule

// File: doc/mul_pipelined.md
Name: mul_pipelined

Overview:
- Two-stage pipelined 32x32 multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
- Companion to the pipelined unsigned divider in the same execute cluster.
- Accepts one operation per cycle with a valid bit and a destination tag, and returns the selected 32-bit half of the 64-bit product two clock edges later.
- Supports a global stall (pipeline hold) and a flush (kill in-flight ops).

Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each op.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operation present this cycle.
- i_op  input  2  op select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_a  input  32  rs1 operand.
- i_b  input  32  rs2 operand.
- i_tag  input  TAG_W  destination tag, passed through unchanged.
- i_stall  input  1  hold both stages; no input accepted, no advance.
- i_flush  input  1  invalidate all in-flight ops.
- o_valid  output  1  result valid this cycle.
- o_result  output  32  selected product half; 0 when o_valid=0.
- o_tag  output  TAG_W  tag of the op in o_result; 0 when o_valid=0.

Behaviour:
- Reset: s1_valid, s2_valid, o_valid = 0; o_result = 0; o_tag = 0; all pipeline data regs = 0. Reset overrides stall and flush.
- Latency 2: an op with i_valid=1 sampled at edge E (no stall) produces o_valid=1 in the cycle after edge E+1. Throughput is 1 op/cycle.
- Operand extension to 33 bits:
  - a is sign-extended for MULH and MULHSU, else zero-extended.
  - b is sign-extended for MULH only.
- Stage 1 (registered at edge E):
  - Split a33 = {ah(17b signed), al(16b unsigned)} and b33 likewise.
  - Register four partial products: pp_ll = al*bl (32b unsigned), pp_lh = al*bh (34b signed), pp_hl = ah*bl (34b signed), pp_hh = ah*bh (34b signed).
  - Also register op, tag and valid.
- Stage 2 (registered at edge E+1):
  - Compute prod = pp_ll + (pp_lh<<16) + (pp_hl<<16) + (pp_hh<<32), all sign-extended to 66 bits, keeping bits [63:0].
  - Select: MUL -> prod[31:0]; all others -> prod[63:32].
  - Register the selection and tag.
- o_result and o_tag are driven from the stage-2 registers, ANDed with s2_valid.
- Stall (i_stall=1, i_flush=0): all stage registers hold, including valids. o_valid and o_result stay stable. i_valid is ignored; the upstream stage must hold its op.
- Flush (i_flush=1): at that edge s1_valid and s2_valid clear to 0. Any i_valid input that cycle is discarded. Flush beats stall when both are asserted. o_valid=0 in the following cycle.
- Bubbles: if i_valid=0, s1_valid=0 and the bubble propagates; no spurious o_valid.
- Data registers may update on bubbles; only the valid-gated outputs are architecturally visible.
- Overflow / wrap: MUL returns the low 32 bits modulo 2^32. There are no exceptions or flags.

Decomposition:
- Shared package mul_pkg:
  - typedef enum logic [1:0] mul_op_t {MUL_LO=2'b00, MUL_HSS=2'b01, MUL_HSU=2'b10, MUL_HUU=2'b11}.
  - localparam MUL_LATENCY = 2.
  - The RV32M funct3 encodings mapped to mul_op_t.
- One natural sub-module: mul_pp_stage, the combinational 33x33 operand extension plus four-partial-product generator. The top module owns the pipeline registers, valid/stall/flush control and the final sum/select.

Test Plan:
- MUL 7*6, tag=3, i_valid for 1 cycle -> 2 edges later o_valid=1 for exactly 1 cycle, o_result=0x0000002A, o_tag=3.
- a=b=0xFFFFFFFF issued back-to-back as MUL, MULH, MULHU, MULHSU on 4 consecutive cycles -> 4 consecutive outputs 0x00000001, 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0x80000000*0x80000000 -> 0xC0000000; MULHU 0x80000000*0x80000000 -> 0x40000000.
- Issue MUL 3*5 then hold i_stall=1 for 3 cycles with the op in stage 2 -> o_valid=1 and o_result=0x0000000F held stable for all stall cycles; after release, the next issued op appears 2 cycles later.
- Ops in both stages, assert i_flush together with i_stall and a new i_valid -> o_valid=0 for the next 3 cycles; the next fresh op returns the correct result.
- Random 10k ops across all 4 ops with random stall/flush/bubbles vs. a 64-bit golden model; rst asserted mid-stream -> all outputs 0 the next cycle and no stale results afterwards.
